// File: rtl/sobel_pkg.sv
// Shared types and dimension helpers for the image memory, filter and frame writer blocks.
package sobel_pkg;

  localparam int DEF_IMG_WIDTH  = 8;
  localparam int DEF_IMG_HEIGHT = 8;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } fw_state_t;

  // Index width for a dimension; a dimension of 1 still gets a 1-bit index.
  function automatic int dim_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = dim_w(DEF_IMG_HEIGHT);
  localparam int COL_W = dim_w(DEF_IMG_WIDTH);

endpackage

// File: rtl/frame_writer_if.sv
// Raster pixel stream (valid/ready) with end-of-line marker.
interface frame_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pixel;
  logic                  in_eol;

  modport master (output in_valid, output in_pixel, output in_eol, input in_ready);
  modport slave  (input in_valid, input in_pixel, input in_eol, output in_ready);
endinterface

// File: rtl/frame_writer_raster_counter.sv
// Row/column raster position counter with clear, advance and explicit wrap.
module raster_counter
  import sobel_pkg::*;
#(
  parameter int WIDTH  = DEF_IMG_WIDTH,
  parameter int HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  output logic [dim_w(HEIGHT)-1:0]  row,
  output logic [dim_w(WIDTH)-1:0]   col,
  output logic                      last_col,
  output logic                      last_pixel
);
  localparam int RW = dim_w(HEIGHT);
  localparam int CW = dim_w(WIDTH);

  logic last_row;

  assign last_col   = (col == CW'(WIDTH - 1));
  assign last_row   = (row == RW'(HEIGHT - 1));
  assign last_pixel = last_col & last_row;

  always_ff @(posedge clk) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Captures a raster pixel stream into an internal frame buffer with a combinational row/col read port.
module frame_writer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  frame_writer_if.slave                 pix,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          eol_err,
  input  logic [dim_w(IMG_HEIGHT)-1:0]  rd_row,
  input  logic [dim_w(IMG_WIDTH)-1:0]   rd_col,
  output logic [DATA_WIDTH-1:0]         rd_pixel
);
  localparam int RW = dim_w(IMG_HEIGHT);
  localparam int CW = dim_w(IMG_WIDTH);

  fw_state_t             state, next;
  logic                  ready, clear, advance, err_clr, hs, wr_en;
  logic                  last_col, last_pixel;
  logic [RW-1:0]         wr_row;
  logic [CW-1:0]         wr_col;
  logic [DATA_WIDTH-1:0] mem [IMG_HEIGHT][IMG_WIDTH];

  assign pix.in_ready = ready;
  assign hs           = pix.in_valid & ready;
  // Reset takes priority over a handshake that coincides with it.
  assign wr_en        = hs & rst;

  raster_counter #(.WIDTH(IMG_WIDTH), .HEIGHT(IMG_HEIGHT)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .advance    (wr_en),
    .row        (wr_row),
    .col        (wr_col),
    .last_col   (last_col),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next       = state;
    ready      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    clear      = 1'b0;
    err_clr    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next    = WRITE;
          clear   = 1'b1;
          err_clr = 1'b1;
        end
      end
      WRITE: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (hs) begin
          advance = 1'b1;
          if (last_pixel) next = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        next       = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Line length is checked against position only; a mismatched pixel is still stored.
  always_ff @(posedge clk) begin
    if (!rst)                                     eol_err <= 1'b0;
    else if (err_clr)                             eol_err <= 1'b0;
    else if (advance && (pix.in_eol != last_col)) eol_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row][wr_col] <= pix.in_pixel;
  end

  always_comb begin
    rd_pixel = '0;
    if ((int'(rd_row) < IMG_HEIGHT) && (int'(rd_col) < IMG_WIDTH))
      rd_pixel = mem[rd_row][rd_col];
  end

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: directed read table plus randomized frames against a raster model.
module tb_frame_writer;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, frame_done, eol_err;
  logic [2:0] rd_row = '0;
  logic [2:0] rd_col = '0;
  logic [7:0] rd_pixel;

  frame_writer_if #(.DATA_WIDTH(8)) bus ();

  frame_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .eol_err    (eol_err),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_pixel   (rd_pixel)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  // Behavioural model: mode 0=idle, 1=capturing, 2=done; pixels indexed linearly in raster order.
  int         m_mode = 0;
  int         m_k = 0;
  bit         m_err = 0;
  logic [7:0] m_mem [NPIX];
  bit         m_known [NPIX];

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t tbl [NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      m_mode = 0; m_k = 0; m_err = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_k = 0; m_err = 0; end
        1: if (bus.in_valid) begin
             m_mem[m_k]   = bus.in_pixel;
             m_known[m_k] = 1'b1;
             if (bus.in_eol != ((m_k % W) == W - 1)) m_err = 1'b1;
             m_k++;
             if (m_k == NPIX) m_mode = 2;
           end
        default: m_mode = 0;
      endcase
    end
  endtask

  // One clock: read check before the edge (old contents), model update at the edge, status after it.
  task automatic cycle();
    int idx;
    @(negedge clk);
    idx = int'(rd_row) * W + int'(rd_col);
    if (m_known[idx]) check("rd_pixel", {24'b0, rd_pixel}, {24'b0, m_mem[idx]});
    @(posedge clk);
    model_step();
    #1;
    if (frame_done === 1'b1) done_cnt++;
    check("status{busy,ready,done,err}", {28'b0, busy, bus.in_ready, frame_done, eol_err},
          {28'b0, m_mode == 1, m_mode == 1, m_mode == 2, m_err});
  endtask

  task automatic check_mem();
    bus.in_valid = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      rd_row = 3'(i / W);
      rd_col = 3'(i % W);
      #1;
      if (m_known[i]) check("mem_readback", {24'b0, rd_pixel}, {24'b0, m_mem[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int gaps, input int bad_k, input int start_k, input int base,
                           input int stop_at, input int ovr, input int fix_rd);
    int guard;
    done_cnt = 0;
    bus.in_valid = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    guard = 0;
    while (m_mode == 1 && m_k < stop_at && guard < 2000) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_pixel = (ovr >= 0 && m_k == 28) ? 8'(ovr) : 8'(base + m_k + 1);
      bus.in_eol   = ((m_k % W) == W - 1) ^ (m_k == bad_k);
      start        = (m_k == start_k);
      rd_row       = fix_rd ? 3'd3 : 3'($urandom_range(0, 7));
      rd_col       = fix_rd ? 3'd4 : 3'($urandom_range(0, 7));
      cycle();
      guard++;
    end
    check("frame_progress_timeout", {31'b0, guard >= 2000}, 32'd0);
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (m_mode == 2) begin
      start = (start_k >= 0);
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      check("frame_done_pulses", done_cnt, 32'd1);
    end
  endtask

  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        tbl[r * W + c] = '{row: 3'(r), col: 3'(c), exp: 8'(r * 8 + c + 1)};
    for (int i = 0; i < NPIX; i++) m_known[i] = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.in_eol   = 1'b0;

    repeat (3) cycle();
    rst = 1'b1;
    cycle();

    // Full frame, no gaps, then directed readback table.
    run_frame(0, -1, -1, 0, NPIX, -1, 0);
    for (int i = 0; i < NPIX; i++) begin
      rd_row = tbl[i].row;
      rd_col = tbl[i].col;
      #1;
      check("table_read", {24'b0, rd_pixel}, {24'b0, tbl[i].exp});
    end
    check("eol_err_clean", {31'b0, eol_err}, 32'd0);
    check("busy_after_done", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Pixel offered in IDLE must not be written, then a gappy frame.
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'hEE;
    rd_row = 3'd0;
    rd_col = 3'd0;
    repeat (3) cycle();
    run_frame(1, -1, -1, 100, NPIX, -1, 0);
    check_mem();

    // Line-length error at row 2 column 5, then start ignored in WRITE/DONE; next start clears the flag.
    run_frame(0, 2 * W + 5, -1, 50, NPIX, -1, 0);
    check("eol_err_sticky", {31'b0, eol_err}, 32'd1);
    run_frame(1, -1, 10, 7, NPIX, -1, 0);
    check("eol_err_cleared", {31'b0, eol_err}, 32'd0);
    check_mem();

    // Reset after 20 pixels, then a complete overwrite.
    run_frame(0, -1, -1, 200, 20, -1, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    done_cnt = 0;
    cycle();
    rst = 1'b1;
    repeat (3) cycle();
    check("no_done_after_reset", done_cnt, 32'd0);
    check_mem();
    run_frame(1, -1, -1, 30, NPIX, -1, 0);
    check_mem();

    // Read-during-write at (3,4): 0x55 then 0xAA.
    run_frame(0, -1, -1, 0, NPIX, 8'h55, 1);
    run_frame(0, -1, -1, 0, NPIX, 8'hAA, 1);
    rd_row = 3'd3;
    rd_col = 3'd4;
    #1;
    check("rdw_final", {24'b0, rd_pixel}, 32'hAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Write-side counterpart of the team's row/col-addressed image memory.
- Accepts a raster-ordered pixel stream (valid/ready), for example Sobel magnitude output, and stores it into an internal IMG_HEIGHT x IMG_WIDTH frame buffer.
- Exposes the same combinational row/col read port that downstream consumers already use.
- Signals frame completion and line-length errors.

Parameters:
- IMG_WIDTH, 8, pixels per line
- IMG_HEIGHT, 8, lines per frame
- DATA_WIDTH, 8, bits per pixel

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  arm a new frame capture; sampled only in IDLE
- in_valid  in  1  stream pixel valid
- in_ready  out  1  stream ready
- in_pixel  in  DATA_WIDTH  stream pixel
- in_eol  in  1  end-of-line marker, expected high on the last pixel of each line
- busy  out  1  high in WRITE
- frame_done  out  1  one-cycle pulse after the last pixel is written
- eol_err  out  1  sticky line-length mismatch flag
- rd_row  in  $clog2(IMG_HEIGHT)  read row
- rd_col  in  $clog2(IMG_WIDTH)  read column
- rd_pixel  out  DATA_WIDTH  combinational read data

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; wr_row=0, wr_col=0.
  - busy=0, frame_done=0, eol_err=0, in_ready=0.
  - Frame buffer contents are not cleared.
- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start==1 -> WRITE; wr_row=0, wr_col=0, eol_err cleared.
- WRITE:
  - in_ready=1, busy=1.
  - Handshake = in_valid & in_ready. On a handshake, mem[wr_row][wr_col] <= in_pixel at that edge.
  - Column advance: wr_col increments; at wr_col==IMG_WIDTH-1 it wraps to 0 and wr_row increments.
  - EOL check on every handshake: in_eol must equal (wr_col==IMG_WIDTH-1). On mismatch, eol_err <= 1 (sticky until the next accepted start or reset).
  - Addressing is position-based only. in_eol never alters the counters, and a mismatched pixel is still written.
  - Handshake at (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE, counters return to 0.
  - No handshake -> hold everything; in_valid gaps of any length are legal.
  - start is ignored in WRITE.
- DONE (exactly one cycle):
  - in_ready=0, busy=0, frame_done=1, then -> IDLE.
  - start is ignored in DONE; the earliest new capture is start sampled on the first IDLE cycle.
- Write latency: pixel visible on rd_pixel from the cycle after its handshake.
- Read port:
  - rd_pixel = mem[rd_row][rd_col], combinational.
  - Reading the location being written in the same cycle returns the old value.
  - rd_row >= IMG_HEIGHT or rd_col >= IMG_WIDTH returns 0. This applies when the parameters are not powers of two.
  - Reads are legal in every state, including during reset.
- Reset mid-frame:
  - Immediate return to IDLE per the reset values above.
  - Pixels already written are retained; no frame_done is issued.
- Widths: counters are $clog2 of their dimension. Compare against IMG_WIDTH-1 / IMG_HEIGHT-1 explicitly; do not rely on natural overflow.

Decomposition:
- Shared package sobel_pkg holds:
  - state enum fw_state_t {IDLE, WRITE, DONE};
  - width helper constants ROW_W=$clog2(IMG_HEIGHT) and COL_W=$clog2(IMG_WIDTH), as functions of the parameters;
  - the default image/data dimensions shared with the memory and filter blocks.
- One sub-module is natural: raster_counter. It holds the row/col counters with clear, advance and wrap, and provides last_col and last_pixel outputs. The image reader side can reuse it later.

Test Plan:
1. Full frame, no gaps:
   - Stimulus: start, then 64 pixels value r*8+c+1 with correct in_eol.
   - Required: frame_done pulses exactly 1 cycle, 1 cycle after the 64th handshake. Then read all 64 locations and check mem[r][c]==r*8+c+1; eol_err=0; busy low after DONE.
2. Backpressure/gaps:
   - Stimulus: in_valid toggling randomly (0/1 per cycle) for the same frame.
   - Required: identical memory contents; frame_done only after handshake 64; in_ready=0 in IDLE/DONE, so a pixel offered before start is not written.
3. EOL error:
   - Stimulus: in_eol asserted at column 5 of row 2.
   - Required: eol_err=1 from the next cycle and stays 1. mem[2][5] is written with its pixel; the frame still completes after 64 pixels. The next start clears eol_err.
4. Start ignored:
   - Stimulus: pulse start in WRITE after 10 pixels, and again in the DONE cycle.
   - Required: counters unaffected, frame completes at pixel 64, FSM stays in IDLE after DONE.
5. Reset mid-frame:
   - Stimulus: rst=0 for one cycle after 20 pixels.
   - Required: busy=0, in_ready=0, frame_done never pulses, mem[0][0..7],[1][0..7],[2][0..3] retain their values. A new start followed by 64 pixels overwrites all locations.
6. Read-during-write:
   - Stimulus: hold rd_row=3, rd_col=4 while pixel (3,4)=0xAA is accepted over a prior frame value of 0x55.
   - Required: rd_pixel=0x55 in the handshake cycle and 0xAA from the next cycle.
